// File: rtl/tt_sweep_pkg.sv
// Shared types and limits for the truth-table sweep/capture stage.
package tt_sweep_pkg;

    localparam int MAX_NUM_IN  = 6;
    localparam int MAX_DUT_LAT = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_e;

    function automatic int tt_w(input int n);
        return 32'sd1 << n;
    endfunction

endpackage

// File: rtl/tt_sweep_capture_tag_pipe.sv
// Delay line for {valid, idx} tags that tracks minterms through the function's latency.
module tt_tag_pipe #(
    parameter int NUM_IN  = 4,
    parameter int DUT_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [NUM_IN-1:0] in_idx,
    output logic              out_valid,
    output logic [NUM_IN-1:0] out_idx
);

    generate
        if (DUT_LAT == 0) begin : g_pass
            logic unused_s;
            assign unused_s  = ^{clk, rst};
            assign out_valid = in_valid;
            assign out_idx   = in_idx;
        end else begin : g_pipe
            logic [DUT_LAT-1:0] vld_q, vld_d;
            logic [NUM_IN-1:0]  idx_q [DUT_LAT];
            logic [NUM_IN-1:0]  idx_d [DUT_LAT];

            // shift the tag one stage per clock
            always_comb begin
                vld_d[0] = in_valid;
                idx_d[0] = in_idx;
                for (int i = 1; i < DUT_LAT; i++) begin
                    vld_d[i] = vld_q[i-1];
                    idx_d[i] = idx_q[i-1];
                end
            end

            // tag registers, cleared so no stale tag survives a reset
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                    idx_q <= '{default: '0};
                end else begin
                    vld_q <= vld_d;
                    idx_q <= idx_d;
                end
            end

            assign out_valid = vld_q[DUT_LAT-1];
            assign out_idx   = idx_q[DUT_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps all minterms into a function, captures y0 into a truth table, hands it off via valid/ready.
// Optional expected-table comparator enabled by defining TT_SWEEP_CMP_EN.
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter int  NUM_IN  = 4,
    parameter int  DUT_LAT = 0,
    localparam int TT_W    = tt_w(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic [NUM_IN-1:0] x,
    input  logic              y0,
    output logic [TT_W-1:0]   tt,
    output logic              tt_valid,
    input  logic              tt_ready
`ifdef TT_SWEEP_CMP_EN
    ,
    input  logic [TT_W-1:0]   exp_tt,
    output logic              mismatch
`endif
);

    localparam logic [NUM_IN-1:0] X_LAST = {NUM_IN{1'b1}};

    state_e              state_q, state_d;
    logic [NUM_IN-1:0]   x_q, x_d;
    logic [TT_W-1:0]     tt_q, tt_d;
    logic                tt_valid_q, tt_valid_d;
    logic                busy_q, busy_d;
    logic                tag_valid_s;
    logic [NUM_IN-1:0]   tag_idx_s;

    tt_tag_pipe #(
        .NUM_IN  (NUM_IN),
        .DUT_LAT (DUT_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (state_q == DRIVE),
        .in_idx    (x_q),
        .out_valid (tag_valid_s),
        .out_idx   (tag_idx_s)
    );

    // next state, minterm counter and table capture
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        tt_d    = tt_q;
        if (tag_valid_s) begin
            tt_d[tag_idx_s] = y0;
        end else begin
            tt_d = tt_q;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    x_d     = '0;
                    tt_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DRIVE: begin
                // with no latency the last sample lands on this same edge
                if (x_q == X_LAST) begin
                    state_d = (DUT_LAT == 0) ? HOLD : DRAIN;
                end else begin
                    x_d = x_q + {{(NUM_IN-1){1'b0}}, 1'b1};
                end
            end
            DRAIN: begin
                if (tag_valid_s && (tag_idx_s == X_LAST)) begin
                    state_d = HOLD;
                end else begin
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (tt_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
        tt_valid_d = (state_d == HOLD);
        busy_d     = (state_d != IDLE);
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            tt_q       <= '0;
            tt_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            tt_q       <= tt_d;
            tt_valid_q <= tt_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign x        = x_q;
    assign tt       = tt_q;
    assign tt_valid = tt_valid_q;
    assign busy     = busy_q;

`ifdef TT_SWEEP_CMP_EN
    logic mismatch_q, mismatch_d;

    // compare once on entry to HOLD, then freeze until the handshake
    always_comb begin
        mismatch_d = 1'b0;
        if (state_d == HOLD) begin
            mismatch_d = (state_q == HOLD) ? mismatch_q : (tt_d != exp_tt);
        end else begin
            mismatch_d = 1'b0;
        end
    end

    // mismatch flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench: two instances (latency 0 and latency 2) driven by small function models.
module tb_tt_sweep_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start2, ready0, ready2;
    logic        busy0, busy2, v0, v2;
    logic [3:0]  x0_s, x2_s;
    logic        y0_0, y0_2;
    logic [15:0] tt0, tt2;
    logic        r1, r2;
    int          fsel;
    int          checks   = 0;
    int          failures = 0;
    int          hs0      = 0;

    always #5 clk = ~clk;

    // 0: AND, 1: parity, 2: constant 0, 3: x0
    function automatic logic fmodel(input int sel, input logic [3:0] xv);
        case (sel)
            0:       return &xv;
            1:       return ^xv;
            2:       return 1'b0;
            default: return xv[0];
        endcase
    endfunction

    assign y0_0 = fmodel(fsel, x0_s);

    always_ff @(posedge clk) begin
        r1 <= fmodel(fsel, x2_s);
        r2 <= r1;
    end
    assign y0_2 = r2;

    always_ff @(posedge clk) begin
        if (v0 && ready0) hs0 <= hs0 + 1;
    end

`ifdef TT_SWEEP_CMP_EN
    logic [15:0] exp0, exp2;
    logic        mis0, mis2;
`endif

    tt_sweep_capture #(.NUM_IN(4), .DUT_LAT(0)) u_lat0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .x(x0_s), .y0(y0_0),
        .tt(tt0), .tt_valid(v0), .tt_ready(ready0)
`ifdef TT_SWEEP_CMP_EN
        , .exp_tt(exp0), .mismatch(mis0)
`endif
    );

    tt_sweep_capture #(.NUM_IN(4), .DUT_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .x(x2_s), .y0(y0_2),
        .tt(tt2), .tt_valid(v2), .tt_ready(ready2)
`ifdef TT_SWEEP_CMP_EN
        , .exp_tt(exp2), .mismatch(mis2)
`endif
    );

    // one sweep: start, x sequence, cleared table, latency to tt_valid, final table
    task automatic sweep(input bit u2, input logic [15:0] exp_v, input int lat_exp,
                         input bit pulse, input string name);
        int n;
        bit seen;
        @(posedge clk); #1;
        checks++;
        if ((u2 ? busy2 : busy0) !== 1'b0) begin
            failures++; $display("FAIL %s_idle busy=%b exp 0", name, u2 ? busy2 : busy0);
        end
        if (u2) start2 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        if (u2) start2 = 1'b0; else start0 = 1'b0;
        n = 1;
        seen = 1'b0;
        checks++;
        if ((u2 ? tt2 : tt0) !== 16'h0000) begin
            failures++; $display("FAIL %s_clear tt=%h exp 0000", name, u2 ? tt2 : tt0);
        end
        checks++;
        if ((u2 ? busy2 : busy0) !== 1'b1) begin
            failures++; $display("FAIL %s_busy busy=%b exp 1", name, u2 ? busy2 : busy0);
        end
        while (!seen && n < 40) begin
            if (n <= 16) begin
                checks++;
                if ((u2 ? x2_s : x0_s) !== 4'(n - 1)) begin
                    failures++;
                    $display("FAIL %s_x cycle %0d x=%0d exp %0d", name, n, u2 ? x2_s : x0_s, n - 1);
                end
            end
            if ((u2 ? v2 : v0) === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (pulse) begin
                    if (u2) start2 = n[0]; else start0 = n[0];
                end
                @(posedge clk); #1;
                n++;
            end
        end
        checks++;
        if (n !== lat_exp) begin
            failures++; $display("FAIL %s_latency tt_valid at T+%0d exp T+%0d", name, n, lat_exp);
        end
        checks++;
        if ((u2 ? tt2 : tt0) !== exp_v) begin
            failures++; $display("FAIL %s_tt tt=%h exp %h", name, u2 ? tt2 : tt0, exp_v);
        end
    endtask

    task automatic handshake(input bit u2);
        if (u2) ready2 = 1'b1; else ready0 = 1'b1;
        @(posedge clk); #1;
        if (u2) ready2 = 1'b0; else ready0 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy0, v0, x0_s, tt0, busy2, v2, x2_s, tt2} !== 44'd0) begin
            failures++; $display("FAIL reset outs=%h exp 0", {busy0, v0, x0_s, tt0, busy2, v2, x2_s, tt2});
        end
        rst = 1'b0;
    endtask

    task automatic test_and_lat0;
        fsel = 0;
        sweep(1'b0, 16'h8000, 17, 1'b0, "and");
        handshake(1'b0);
        checks++;
        if ({v0, busy0} !== 2'b00) begin
            failures++; $display("FAIL and_release valid,busy=%b exp 00", {v0, busy0});
        end
        checks++;
        if (tt0 !== 16'h8000) begin
            failures++; $display("FAIL and_keep tt=%h exp 8000", tt0);
        end
    endtask

    task automatic test_parity_lat2;
        fsel = 1;
        sweep(1'b1, 16'h6996, 19, 1'b0, "parity");
        handshake(1'b1);
        checks++;
        if ({v2, busy2} !== 2'b00) begin
            failures++; $display("FAIL parity_release valid,busy=%b exp 00", {v2, busy2});
        end
    endtask

    task automatic test_backpressure;
        int hs_start;
        fsel = 0;
        sweep(1'b0, 16'h8000, 17, 1'b1, "bp");
        hs_start = hs0;
        for (int i = 0; i < 5; i++) begin
            start0 = 1'b1;
            @(posedge clk); #1;
            checks++;
            if ({v0, busy0, tt0, x0_s} !== {2'b11, 16'h8000, 4'hF}) begin
                failures++;
                $display("FAIL bp_hold cycle %0d valid,busy=%b tt=%h x=%h exp 11 8000 f", i, {v0, busy0}, tt0, x0_s);
            end
        end
        ready0 = 1'b1;
        @(posedge clk); #1;
        ready0 = 1'b0;
        start0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({v0, busy0, x0_s} !== {2'b00, 4'hF}) begin
                failures++; $display("FAIL bp_nosweep cycle %0d valid,busy=%b x=%h exp 00 f", i, {v0, busy0}, x0_s);
            end
        end
        checks++;
        if (hs0 - hs_start !== 1) begin
            failures++; $display("FAIL bp_handshakes count=%0d exp 1", hs0 - hs_start);
        end
    endtask

    task automatic test_reset_mid_sweep;
        fsel = 3;
        @(posedge clk); #1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        checks++;
        if ({x0_s, tt0} !== {4'd7, 16'h002A}) begin
            failures++; $display("FAIL rstmid_pre x=%0d tt=%h exp 7 002a", x0_s, tt0);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy0, v0, x0_s, tt0} !== 22'd0) begin
            failures++; $display("FAIL rstmid_async outs=%h exp 0", {busy0, v0, x0_s, tt0});
        end
        @(posedge clk); #1;
        checks++;
        if ({busy0, v0, x0_s, tt0} !== 22'd0) begin
            failures++; $display("FAIL rstmid_held outs=%h exp 0", {busy0, v0, x0_s, tt0});
        end
        rst = 1'b0;
        sweep(1'b0, 16'hAAAA, 17, 1'b0, "rstmid_after");
        handshake(1'b0);
    endtask

    task automatic test_compare;
`ifdef TT_SWEEP_CMP_EN
        fsel = 1;
        exp2 = 16'h6996;
        sweep(1'b1, 16'h6996, 19, 1'b0, "cmp_match");
        checks++;
        if (mis2 !== 1'b0) begin
            failures++; $display("FAIL cmp_match mismatch=%b exp 0", mis2);
        end
        handshake(1'b1);
        fsel = 2;
        exp0 = 16'h6996;
        sweep(1'b0, 16'h0000, 17, 1'b0, "cmp_diff");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mis0 !== 1'b1) begin
                failures++; $display("FAIL cmp_diff cycle %0d mismatch=%b exp 1", i, mis0);
            end
            @(posedge clk); #1;
        end
        handshake(1'b0);
        checks++;
        if (mis0 !== 1'b0) begin
            failures++; $display("FAIL cmp_release mismatch=%b exp 0", mis0);
        end
`endif
    endtask

    task automatic test_back_to_back;
        fsel = 3;
        ready0 = 1'b1;
        sweep(1'b0, 16'hAAAA, 17, 1'b0, "b2b_first");
        sweep(1'b0, 16'hAAAA, 17, 1'b0, "b2b_second");
        @(posedge clk); #1;
        ready0 = 1'b0;
        checks++;
        if ({v0, busy0} !== 2'b00) begin
            failures++; $display("FAIL b2b_release valid,busy=%b exp 00", {v0, busy0});
        end
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0; start2 = 1'b0;
        ready0 = 1'b0; ready2 = 1'b0;
        fsel = 0;
`ifdef TT_SWEEP_CMP_EN
        exp0 = 16'h0000;
        exp2 = 16'h0000;
`endif
        test_reset();
        test_and_lat0();
        test_parity_lat2();
        test_backpressure();
        test_reset_mid_sweep();
        test_compare();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
